// File: rtl/d_edge_capture.sv
// ============================================================================
// Module   : d_edge_capture
// Summary  : Glitch-filtered edge detector with a valid/ready event register,
//            saturating event counter and sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module d_edge_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             D_i,
    input  logic             ev_ready,
    input  logic             ovf_clr,
    output logic             level_o,
    output logic             ev_valid,
    output logic             ev_rise,
    output logic [CNT_W-1:0] ev_count,
    output logic             overflow
);

    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] c_STABLE = QW'(STABLE_CYCLES);
    localparam logic [QW-1:0] c_ONE    = QW'(1);

    typedef enum logic [1:0] {
        STB_LOW  = 2'd0,
        QUAL_HI  = 2'd1,
        STB_HIGH = 2'd2,
        QUAL_LO  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [QW-1:0] r_cnt,   w_cnt_nxt;
    logic          w_commit;
    logic          w_commit_rise;
    logic          w_xfer;
    logic          w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STB_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Commit on the sample that completes STABLE_CYCLES identical samples.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_commit      = 1'b0;
        w_commit_rise = 1'b0;
        case (r_state)
            STB_LOW: begin
                if (D_i) begin
                    if (STABLE_CYCLES == 1) begin
                        w_commit      = 1'b1;
                        w_commit_rise = 1'b1;
                        w_state_nxt   = STB_HIGH;
                        w_cnt_nxt     = '0;
                    end else begin
                        w_state_nxt = QUAL_HI;
                        w_cnt_nxt   = c_ONE;
                    end
                end
            end
            QUAL_HI: begin
                if (!D_i) begin
                    w_state_nxt = STB_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt + c_ONE == c_STABLE) begin
                    w_commit      = 1'b1;
                    w_commit_rise = 1'b1;
                    w_state_nxt   = STB_HIGH;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            STB_HIGH: begin
                if (!D_i) begin
                    if (STABLE_CYCLES == 1) begin
                        w_commit    = 1'b1;
                        w_state_nxt = STB_LOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = QUAL_LO;
                        w_cnt_nxt   = c_ONE;
                    end
                end
            end
            QUAL_LO: begin
                if (D_i) begin
                    w_state_nxt = STB_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt + c_ONE == c_STABLE) begin
                    w_commit    = 1'b1;
                    w_state_nxt = STB_LOW;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            default: begin
                w_state_nxt = STB_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_xfer = ev_valid & ev_ready;
    assign w_drop = w_commit & ev_valid & ~ev_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_o  <= 1'b0;
            ev_valid <= 1'b0;
            ev_rise  <= 1'b0;
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_commit) begin
                level_o <= ~level_o;
                if (ev_count != {CNT_W{1'b1}}) begin
                    ev_count <= ev_count + 1'b1;
                end
            end
            // A transfer frees the slot in the same cycle a new event may load.
            if (w_commit && (!ev_valid || w_xfer)) begin
                ev_valid <= 1'b1;
                ev_rise  <= w_commit_rise;
            end else if (w_xfer) begin
                ev_valid <= 1'b0;
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_d_edge_capture.sv
// ============================================================================
// Module   : tb_d_edge_capture
// Summary  : Directed self-checking bench for d_edge_capture (S=4, S=1, CNT_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_d_edge_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a: S=4/CNT_W=8, b: S=1/CNT_W=8, c: S=1/CNT_W=2
    logic       a_d = 0, a_rdy = 0, a_clr = 0;
    logic       a_lvl, a_vld, a_rise, a_ovf;
    logic [7:0] a_cnt;
    logic       b_d = 0, b_rdy = 0, b_clr = 0;
    logic       b_lvl, b_vld, b_rise, b_ovf;
    logic [7:0] b_cnt;
    logic       c_d = 0, c_rdy = 0, c_clr = 0;
    logic       c_lvl, c_vld, c_rise, c_ovf;
    logic [1:0] c_cnt;

    int vec = 0;
    int err = 0;

    d_edge_capture #(.STABLE_CYCLES(4), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .D_i(a_d), .ev_ready(a_rdy), .ovf_clr(a_clr),
        .level_o(a_lvl), .ev_valid(a_vld), .ev_rise(a_rise), .ev_count(a_cnt), .overflow(a_ovf)
    );
    d_edge_capture #(.STABLE_CYCLES(1), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .D_i(b_d), .ev_ready(b_rdy), .ovf_clr(b_clr),
        .level_o(b_lvl), .ev_valid(b_vld), .ev_rise(b_rise), .ev_count(b_cnt), .overflow(b_ovf)
    );
    d_edge_capture #(.STABLE_CYCLES(1), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .D_i(c_d), .ev_ready(c_rdy), .ovf_clr(c_clr),
        .level_o(c_lvl), .ev_valid(c_vld), .ev_rise(c_rise), .ev_count(c_cnt), .overflow(c_ovf)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_d = 0; a_rdy = 0; a_clr = 0;
        b_d = 0; b_rdy = 0; b_clr = 0;
        c_d = 0; c_rdy = 0; c_clr = 0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tick(20);
        vec++; if ({a_lvl, a_vld, a_ovf} !== 3'b000) begin err++; $display("FAIL reset_flags: got %b exp 000", {a_lvl, a_vld, a_ovf}); end
        vec++; if (a_cnt !== 8'd0) begin err++; $display("FAIL reset_count: got %0d exp 0", a_cnt); end
    endtask

    task automatic test_rise_latency();
        do_reset();
        a_rdy = 1; a_d = 1;
        tick(3);
        vec++; if ({a_lvl, a_vld} !== 2'b00) begin err++; $display("FAIL rise_early: got %b exp 00", {a_lvl, a_vld}); end
        tick(1);
        vec++; if ({a_lvl, a_vld, a_rise} !== 3'b111) begin err++; $display("FAIL rise_commit: got %b exp 111", {a_lvl, a_vld, a_rise}); end
        vec++; if (a_cnt !== 8'd1) begin err++; $display("FAIL rise_count: got %0d exp 1", a_cnt); end
        tick(1);
        vec++; if (a_vld !== 1'b0) begin err++; $display("FAIL rise_single_valid: got %b exp 0", a_vld); end
        tick(5);
        vec++; if ({a_lvl, a_vld, a_cnt} !== {2'b10, 8'd1}) begin err++; $display("FAIL rise_steady: got %b exp 1000000001", {a_lvl, a_vld, a_cnt}); end
    endtask

    task automatic test_glitch();
        do_reset();
        a_rdy = 1; a_d = 1;
        tick(3);
        a_d = 0;
        tick(6);
        vec++; if ({a_lvl, a_vld, a_cnt} !== 10'd0) begin err++; $display("FAIL glitch: got %b exp 0000000000", {a_lvl, a_vld, a_cnt}); end
    endtask

    task automatic test_overflow();
        do_reset();
        b_d = 1; tick(1);
        vec++; if ({b_vld, b_rise, b_cnt} !== {2'b11, 8'd1}) begin err++; $display("FAIL ovf_first: got %b exp 1100000001", {b_vld, b_rise, b_cnt}); end
        tick(1);
        b_d = 0; tick(1);
        vec++; if ({b_vld, b_rise, b_ovf, b_lvl} !== 4'b1110) begin err++; $display("FAIL ovf_drop: got %b exp 1110", {b_vld, b_rise, b_ovf, b_lvl}); end
        tick(1);
        b_d = 1; tick(2);
        vec++; if (b_cnt !== 8'd3) begin err++; $display("FAIL ovf_count: got %0d exp 3", b_cnt); end
        vec++; if ({b_vld, b_rise, b_ovf, b_lvl} !== 4'b1111) begin err++; $display("FAIL ovf_held: got %b exp 1111", {b_vld, b_rise, b_ovf, b_lvl}); end
        b_clr = 1; tick(1); b_clr = 0;
        vec++; if (b_ovf !== 1'b0) begin err++; $display("FAIL ovf_clear: got %b exp 0", b_ovf); end
        b_clr = 1; b_d = 0; tick(1); b_clr = 0;
        vec++; if ({b_ovf, b_cnt} !== {1'b1, 8'd4}) begin err++; $display("FAIL ovf_set_wins: got %b exp 100000100", {b_ovf, b_cnt}); end
        b_rdy = 1; tick(1);
        vec++; if (b_vld !== 1'b0) begin err++; $display("FAIL ovf_transfer: got %b exp 0", b_vld); end
    endtask

    task automatic test_back_to_back();
        // b: level 0 after the overflow test; ready held high
        b_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            b_d = ~b_d;
            tick(1);
            vec++; if ({b_vld, b_rise} !== {1'b1, b_d}) begin err++; $display("FAIL b2b_%0d: got %b exp %b", i, {b_vld, b_rise}, {1'b1, b_d}); end
        end
        vec++; if ({b_cnt, b_ovf} !== {8'd8, 1'b1}) begin err++; $display("FAIL b2b_count: got %b exp 000010001", {b_cnt, b_ovf}); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        do_reset();
        c_rdy = 1;
        for (int i = 0; i < 5; i++) begin
            c_d = ~c_d;
            tick(1);
            vec++; if (c_cnt !== exp_cnt[i]) begin err++; $display("FAIL sat_%0d: got %0d exp %0d", i, c_cnt, exp_cnt[i]); end
        end
        vec++; if (c_ovf !== 1'b0) begin err++; $display("FAIL sat_ovf: got %b exp 0", c_ovf); end
    endtask

    task automatic test_reset_mid_qual();
        do_reset();
        a_rdy = 0; a_d = 1;
        tick(4);
        a_d = 0;
        tick(4);
        vec++; if ({a_vld, a_ovf, a_cnt} !== {2'b11, 8'd2}) begin err++; $display("FAIL mq_pre: got %b exp 1100000010", {a_vld, a_ovf, a_cnt}); end
        a_d = 1;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        vec++; if ({a_lvl, a_vld, a_rise, a_ovf, a_cnt} !== 12'd0) begin err++; $display("FAIL mq_async: got %b exp 0", {a_lvl, a_vld, a_rise, a_ovf, a_cnt}); end
        tick(1);
        rst_n = 1'b1;
        tick(3);
        vec++; if ({a_lvl, a_vld} !== 2'b00) begin err++; $display("FAIL mq_partial_discarded: got %b exp 00", {a_lvl, a_vld}); end
        tick(1);
        vec++; if ({a_lvl, a_vld, a_rise, a_cnt} !== {3'b111, 8'd1}) begin err++; $display("FAIL mq_rise: got %b exp 11100000001", {a_lvl, a_vld, a_rise, a_cnt}); end
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_saturate();
        test_reset_mid_qual();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

`default_nettype wire
